// File: rtl/ir_nec_send.sv
// NEC infrared transmitter: leader, 32 data bits (MSB first), stop mark and frame gap,
// with a 38 kHz carrier on o_ir and an active-low envelope on o_env_n. Repeat codes: IR_NEC_SEND_REPEAT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for i_start, counters held at zero
// S_LEAD_MARK | 9 ms leader mark, frame timer restarts here
// S_LEAD_SPACE| 4.5 ms leader space
// S_BIT_MARK  | 560 us mark preceding every data bit
// S_BIT_SPACE | 560 us (bit 0) or 1690 us (bit 1) space, then shift
// S_STOP_MARK | 560 us trailing mark
// S_GAP       | space until 110 ms after leader start
// S_REP_MARK  | 9 ms repeat-code mark (repeat build only)
// S_REP_SPACE | 2.25 ms repeat-code space (repeat build only)
// S_REP_STOP  | 560 us repeat-code stop mark (repeat build only)
module ir_nec_send #(
    parameter int CLK_DIV       = 50,
    parameter int CARRIER_DIV   = 1316,
    parameter int CARRIER_HIGH  = 439,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_SPACE_US = 560,
    parameter int ONE_SPACE_US  = 1690,
    parameter int STOP_MARK_US  = 560,
    parameter int REP_SPACE_US  = 2250,
    parameter int FRAME_US      = 110000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    output logic        o_ir,
    output logic        o_env_n,
    output logic        o_busy,
    output logic        o_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CARR_LAST   = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CARR_HIGH   = CW'(CARRIER_HIGH);
    localparam logic [16:0]   FRAME_LAST  = 17'(FRAME_US - 1);
    localparam logic [13:0]   T_LEAD_MARK  = 14'(LEAD_MARK_US);
    localparam logic [13:0]   T_LEAD_SPACE = 14'(LEAD_SPACE_US);
    localparam logic [13:0]   T_BIT_MARK   = 14'(BIT_MARK_US);
    localparam logic [13:0]   T_ZERO_SPACE = 14'(ZERO_SPACE_US);
    localparam logic [13:0]   T_ONE_SPACE  = 14'(ONE_SPACE_US);
    localparam logic [13:0]   T_STOP_MARK  = 14'(STOP_MARK_US);
    localparam logic [13:0]   T_REP_SPACE  = 14'(REP_SPACE_US);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LEAD_MARK  = 4'd1,
        S_LEAD_SPACE = 4'd2,
        S_BIT_MARK   = 4'd3,
        S_BIT_SPACE  = 4'd4,
        S_STOP_MARK  = 4'd5,
        S_GAP        = 4'd6,
        S_REP_MARK   = 4'd7,
        S_REP_SPACE  = 4'd8,
        S_REP_STOP   = 4'd9
    } state_t;

    state_t       state, state_nxt;
    logic [31:0]  shreg, shreg_nxt;
    logic [4:0]   bit_cnt, bit_cnt_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [13:0]  dur, dur_nxt;
    logic [16:0]  frame, frame_nxt;
    logic [CW-1:0] carr, carr_nxt;
    logic [13:0]  dur_limit;
    logic         tick, seg_end, frame_end, entering;
    logic         ir_nxt, env_n_nxt, busy_nxt, done_nxt;

    function automatic logic is_mark(input state_t s);
`ifdef IR_NEC_SEND_REPEAT_EN
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK) ||
               (s == S_REP_MARK)  || (s == S_REP_STOP);
`else
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
`endif
    endfunction

    always_comb begin
        dur_limit = T_BIT_MARK;
        case (state)
            S_LEAD_MARK:  dur_limit = T_LEAD_MARK;
            S_LEAD_SPACE: dur_limit = T_LEAD_SPACE;
            S_BIT_MARK:   dur_limit = T_BIT_MARK;
            S_BIT_SPACE:  dur_limit = shreg[31] ? T_ONE_SPACE : T_ZERO_SPACE;
            S_STOP_MARK:  dur_limit = T_STOP_MARK;
`ifdef IR_NEC_SEND_REPEAT_EN
            S_REP_MARK:   dur_limit = T_LEAD_MARK;
            S_REP_SPACE:  dur_limit = T_REP_SPACE;
            S_REP_STOP:   dur_limit = T_STOP_MARK;
`endif
            default:      dur_limit = T_BIT_MARK;
        endcase
    end

    assign tick      = (presc == PRESC_LAST);
    assign seg_end   = tick && (dur == (dur_limit - 14'd1));
    assign frame_end = tick && (frame == FRAME_LAST);

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    shreg_nxt   = i_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK:  if (seg_end) state_nxt = S_LEAD_SPACE;
            S_LEAD_SPACE: if (seg_end) state_nxt = S_BIT_MARK;
            S_BIT_MARK:   if (seg_end) state_nxt = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (seg_end) begin
                    shreg_nxt   = {shreg[30:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    state_nxt   = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK:  if (seg_end) state_nxt = S_GAP;
            S_GAP: begin
                // o_done is registered one cycle ahead, so it already carries the repeat decision
                if (frame_end) begin
`ifdef IR_NEC_SEND_REPEAT_EN
                    state_nxt = o_done ? S_IDLE : S_REP_MARK;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef IR_NEC_SEND_REPEAT_EN
            S_REP_MARK:   if (seg_end) state_nxt = S_REP_SPACE;
            S_REP_SPACE:  if (seg_end) state_nxt = S_REP_STOP;
            S_REP_STOP:   if (seg_end) state_nxt = S_GAP;
`endif
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign entering = (state_nxt != state);

    always_comb begin
        presc_nxt = '0;
        dur_nxt   = '0;
        frame_nxt = '0;
        carr_nxt  = '0;
        if (state_nxt != S_IDLE) begin
            if (!entering) begin
                presc_nxt = tick ? '0 : presc + 1'b1;
                dur_nxt   = (tick && state != S_GAP) ? dur + 14'd1 : dur;
            end
            if (!(entering && (state_nxt == S_LEAD_MARK || state_nxt == S_REP_MARK)))
                frame_nxt = tick ? frame + 17'd1 : frame;
            if (is_mark(state_nxt) && !entering)
                carr_nxt = (carr == CARR_LAST) ? '0 : carr + 1'b1;
        end
    end

    // Outputs are computed from next-cycle values so they can all be registered.
    always_comb begin
        done_nxt  = (state_nxt == S_GAP) && (frame_nxt == FRAME_LAST) && (presc_nxt == PRESC_LAST);
`ifdef IR_NEC_SEND_REPEAT_EN
        done_nxt  = done_nxt && !i_start;
`endif
        busy_nxt  = (state_nxt != S_IDLE) && !done_nxt;
        env_n_nxt = !is_mark(state_nxt);
        ir_nxt    = is_mark(state_nxt) && (carr_nxt < CARR_HIGH);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            presc   <= '0;
            dur     <= '0;
            frame   <= '0;
            carr    <= '0;
            o_ir    <= 1'b0;
            o_env_n <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            presc   <= presc_nxt;
            dur     <= dur_nxt;
            frame   <= frame_nxt;
            carr    <= carr_nxt;
            o_ir    <= ir_nxt;
            o_env_n <= env_n_nxt;
            o_busy  <= busy_nxt;
            o_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ir_nec_send.sv
// Bench for ir_nec_send with shortened timings; per-cycle comparison against a segment-list model
// and an envelope decoder. Repeat-code scenario runs when IR_NEC_SEND_REPEAT_EN is defined.
module tb_ir_nec_send;

    localparam int TCLK_DIV  = 2;
    localparam int TCAR_DIV  = 13;
    localparam int TCAR_HIGH = 4;
    localparam int TLEAD     = 90;
    localparam int TLSP      = 45;
    localparam int TBIT      = 6;
    localparam int TONE      = 17;
    localparam int TREPSP    = 22;
    localparam int TFRAME    = 1100;
    localparam int FRAME_CYC = TFRAME * TCLK_DIV;
    localparam int THRESH    = (TBIT + TONE) * TCLK_DIV / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_data;
    logic        o_ir, o_env_n, o_busy, o_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_env [FRAME_CYC];
    logic exp_ir  [FRAME_CYC];
    logic act_env [FRAME_CYC];
    int   mpos;

    always #5 clk = ~clk;

    ir_nec_send #(
        .CLK_DIV(TCLK_DIV), .CARRIER_DIV(TCAR_DIV), .CARRIER_HIGH(TCAR_HIGH),
        .LEAD_MARK_US(TLEAD), .LEAD_SPACE_US(TLSP), .BIT_MARK_US(TBIT),
        .ZERO_SPACE_US(TBIT), .ONE_SPACE_US(TONE), .STOP_MARK_US(TBIT),
        .REP_SPACE_US(TREPSP), .FRAME_US(TFRAME)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_data(i_data),
        .o_ir(o_ir), .o_env_n(o_env_n), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic add_seg(input bit mark, input int len_us);
        for (int c = 0; c < len_us * TCLK_DIV; c++) begin
            if (mpos < FRAME_CYC) begin
                exp_env[mpos] = !mark;
                exp_ir[mpos]  = mark && ((c % TCAR_DIV) < TCAR_HIGH);
            end
            mpos++;
        end
    endtask

    task automatic model_frame(input logic [31:0] data, input bit rep);
        mpos = 0;
        add_seg(1'b1, TLEAD);
        if (rep) begin
            add_seg(1'b0, TREPSP);
            add_seg(1'b1, TBIT);
        end else begin
            add_seg(1'b0, TLSP);
            for (int i = 31; i >= 0; i--) begin
                add_seg(1'b1, TBIT);
                add_seg(1'b0, data[i] ? TONE : TBIT);
            end
            add_seg(1'b1, TBIT);
        end
        while (mpos < FRAME_CYC) begin
            exp_env[mpos] = 1'b1;
            exp_ir[mpos]  = 1'b0;
            mpos++;
        end
    endtask

    task automatic decode_env(output logic [31:0] word);
        int idx;
        int len;
        word = '0;
        idx  = 0;
        while (idx < FRAME_CYC && act_env[idx] === 1'b0) idx++;
        while (idx < FRAME_CYC && act_env[idx] === 1'b1) idx++;
        for (int b = 0; b < 32; b++) begin
            while (idx < FRAME_CYC && act_env[idx] === 1'b0) idx++;
            len = 0;
            while (idx < FRAME_CYC && act_env[idx] === 1'b1) begin
                idx++;
                len++;
            end
            word = {word[30:0], (len > THRESH)};
        end
    endtask

    task automatic send(input logic [31:0] data);
        @(negedge clk);
        i_data  = data;
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    // Acceptance edge has just passed; compare every cycle of one frame period.
    task automatic check_frame(input logic [31:0] data, input bit rep, input bit noise,
                               input bit exp_done, input int release_at, input bit pulse_at_done);
        int    bad [4];
        int    fk  [4];
        logic  fg  [4];
        logic  fw  [4];
        logic  obs [4];
        logic  ev  [4];
        string nm  [4];
        logic [31:0] word;
        int    last;
        nm = '{"env_n", "ir", "busy", "done"};
        last = FRAME_CYC - 1;
        for (int j = 0; j < 4; j++) begin
            bad[j] = 0; fk[j] = 0; fg[j] = 1'b0; fw[j] = 1'b0;
        end
        model_frame(data, rep);
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            act_env[k] = o_env_n;
            obs = '{o_env_n, o_ir, o_busy, o_done};
            ev  = '{exp_env[k], exp_ir[k], (k == last) ? !exp_done : 1'b1, (k == last) && exp_done};
            for (int j = 0; j < 4; j++) begin
                if (obs[j] !== ev[j]) begin
                    if (bad[j] == 0) begin
                        fk[j] = k; fg[j] = obs[j]; fw[j] = ev[j];
                    end
                    bad[j]++;
                end
            end
            if (noise && k < last - 3) begin
                i_start = ($urandom_range(0, 7) == 0);
                i_data  = $urandom;
            end else if (noise) begin
                i_start = 1'b0;
            end
            if (k == release_at) i_start = 1'b0;
            if (k == last && pulse_at_done) i_start = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (bad[j] !== 0)
                $display("FAIL frame_%s data=%h rep=%0d cycle=%0d got=%b want=%b bad_cycles=%0d",
                         nm[j], data, rep, fk[j], fg[j], fw[j], bad[j]);
            else
                n_pass++;
        end
        if (!rep) begin
            decode_env(word);
            n_checks++;
            if (word !== data)
                $display("FAIL loopback_decode got=%h want=%h", word, data);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_data = '0;
        #12;
        n_checks++; if (o_ir !== 1'b0)    $display("FAIL reset_ir got=%b want=0", o_ir);       else n_pass++;
        n_checks++; if (o_env_n !== 1'b1) $display("FAIL reset_env_n got=%b want=1", o_env_n); else n_pass++;
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL reset_busy got=%b want=0", o_busy);   else n_pass++;
        n_checks++; if (o_done !== 1'b0)  $display("FAIL reset_done got=%b want=0", o_done);   else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL idle_busy got=%b want=0", o_busy);    else n_pass++;
        n_checks++; if (o_env_n !== 1'b1) $display("FAIL idle_env_n got=%b want=1", o_env_n);  else n_pass++;
    endtask

    task automatic test_frames();
        logic [31:0] d;
        send(32'h00FF_A25D);
        check_frame(32'h00FF_A25D, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        repeat (3) @(negedge clk);
        send(32'h12ED_40BF);
        check_frame(32'h12ED_40BF, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            d = $urandom;
            send(d);
            check_frame(d, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] d;
        d = $urandom;
        send(d);
        check_frame(d, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL done_pulse_busy got=%b want=0", o_busy);   else n_pass++;
        n_checks++; if (o_env_n !== 1'b1) $display("FAIL done_pulse_env_n got=%b want=1", o_env_n); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL done_pulse_busy2 got=%b want=0", o_busy);  else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        send(a);
        check_frame(a, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send(b);
        check_frame(b, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = $urandom;
        send(d);
        repeat (20) @(negedge clk);
        n_checks++; if (o_env_n !== 1'b0) $display("FAIL mid_lead_env_n got=%b want=0", o_env_n); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (o_ir !== 1'b0)    $display("FAIL async_rst_ir got=%b want=0", o_ir);       else n_pass++;
        n_checks++; if (o_env_n !== 1'b1) $display("FAIL async_rst_env_n got=%b want=1", o_env_n); else n_pass++;
        n_checks++; if (o_busy !== 1'b0)  $display("FAIL async_rst_busy got=%b want=0", o_busy);   else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (o_env_n !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL no_resume got env_n=%b busy=%b want env_n=1 busy=0", o_env_n, o_busy);
        else n_pass++;
        d = $urandom;
        send(d);
        check_frame(d, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    endtask

`ifdef IR_NEC_SEND_REPEAT_EN
    task automatic test_repeat();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        i_data  = d;
        i_start = 1'b1;
        @(posedge clk);
        check_frame(d, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        check_frame(d, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        check_frame(d, 1'b1, 1'b0, 1'b1, 100, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL repeat_release got busy=%b done=%b want busy=0 done=0", o_busy, o_done);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef IR_NEC_SEND_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
